spi_ahb_fifo_bridge: RTL and testbench
======================================

// Module: spi_ahb_fifo_bridge
// PURPOSE
//  Parametrised AHB-slave-to-SPI-master bridge. It replaces the single-byte connector with
//  independent TX and RX FIFOs, a small register map, sticky error flags and an interrupt.
//  Sits between the AHB decode (hsel) and the SPI master core, which it drives through the
//  same data/ready/busy handshake as before.
// PARAMETERS
//  DATA_W      8    SPI word width in bits (1..32)
//  TX_DEPTH    8    TX FIFO entries (power of 2, >=2)
//  RX_DEPTH    8    RX FIFO entries (power of 2, >=2)
//  ADDR_BASE   'h0  haddr[15:0] base of the register window
// PORTS
//  clk             in   1       system clock, all logic on posedge
//  rst_n           in   1       asynchronous, active-low reset
//  hsel            in   1       slave select (address phase)
//  hwrite          in   1       1=write, 0=read (address phase)
//  haddr           in   32      byte address (address phase); [15:0] decoded
//  hwdata          in   32      write data, valid in the data phase (cycle after address)
//  hrdata          out  32      registered read data, valid in the data phase
//  spi_data_out    in   DATA_W  word received by the SPI core; valid when spi_busy falls
//  spi_busy        in   1       SPI core transferring
//  spi_data_in     out  DATA_W  word to transmit
//  spi_ready_send  out  1       request to SPI core; held until spi_busy seen high
//  irq             out  1       level interrupt = |(STATUS & IRQ_EN)
// BEHAVIOUR
//  Register map (offset from ADDR_BASE):
//   0x0 DATA : write pushes hwdata[DATA_W-1:0] to TX; read pops RX.
//   0x4 STAT : [0] tx_empty [1] tx_full [2] rx_empty [3] rx_full [4] busy
//              (spi_busy|spi_ready_send|!tx_empty) [8] tx_ovf [9] rx_ovf [10] rx_udf
//              (sticky, write-1-to-clear) [23:16] rx_count.
//   0x8 CTRL : [0] enable [1] tx_flush [2] rx_flush (self-clearing, 1-cycle strobes)
//              [10:8] IRQ_EN for STAT[2:0] inverted (bit 8: tx_empty, bit 9: !rx_empty,
//              bit 10: any sticky error).
//   Other offsets: reads return 0, writes are ignored.
//  Bus: address phase latched when hsel=1. Writes commit on the next cycle using hwdata.
//   Reads to DATA pop in the address-phase cycle; hrdata is updated at that edge.
//   Back-to-back accesses are allowed every cycle.
//  TX push when full: word dropped, tx_ovf<=1. RX pop when empty: hrdata=0, rx_udf<=1.
//  SPI FSM states IDLE -> REQ -> BUSY -> IDLE:
//   IDLE: if enable && !tx_empty && !spi_busy: spi_data_in<=TX head, pop,
//         spi_ready_send<=1 -> REQ.
//   REQ: hold spi_ready_send; when spi_busy=1: spi_ready_send<=0 -> BUSY.
//   BUSY: on spi_busy=0: push spi_data_out to RX (if full: drop, rx_ovf<=1) -> IDLE.
//   IDLE->REQ costs 1 cycle, so sustained throughput is one word per SPI transfer + 2 clk.
//  Simultaneous events: TX push and FSM pop in the same cycle on a full FIFO succeed
//   (pop first). An RX pop and push on a full FIFO succeed with no rx_ovf. A W1C and a new
//   error in the same cycle leave the flag set.
//  Flush: empties the FIFO pointers next cycle. A word already in REQ/BUSY completes; for
//   rx_flush, its RX word is still pushed.
//  Clearing enable mid-transfer: the current word completes, then the FSM stays in IDLE.
//  Reset (rst_n=0, any time): FIFOs empty, FSM IDLE, CTRL=0, sticky=0, hrdata=0,
//   spi_data_in=0, spi_ready_send=0, irq=0.
//   Deassertion is synchronised externally.
// STRUCTURE
//  spi_bridge_pkg: register offsets, STAT/CTRL bit indices, FSM state encodings.
//  Sub-module sync_fifo #(W,DEPTH): push/pop/full/empty/count with async active-low
//   reset and a flush input. Instantiated twice (TX, RX).
//  Top level holds the bus decode, registers, sticky flags, FSM and irq.
// TESTING
//  1. enable=1, write DATA 0xA5 -> ready_send rises 2 clk later, spi_data_in=0xA5; model
//     returns 0x3C -> STAT.rx_count=1, DATA read=0x3C.
//  2. enable=0, 9 writes with TX_DEPTH=8 -> tx_full=1, tx_ovf=1, 9th word lost;
//     W1C 0x100 -> tx_ovf=0.
//  3. Read DATA with RX empty -> hrdata=0, rx_udf=1. With IRQ_EN[10]=1 -> irq=1.
//  4. Fill RX to 8 with reads stalled, one more transfer -> rx_ovf=1, first 8 words
//     read back in order.
//  5. Assert rst_n=0 during BUSY -> all outputs 0 next edge, and no RX push after release.
//  6. Back-to-back write/read every cycle with a push/pop collision on a full TX
//     -> no loss, no ovf.

Source files
------------

// File: rtl/spi_ahb_fifo_bridge_pkg.sv
// Shared register offsets, STAT/CTRL bit positions and FSM encodings for the AHB-to-SPI bridge.
// Imported by the bridge top level; contains no logic of its own.
package spi_bridge_pkg;

  localparam logic [15:0] OFF_DATA = 16'h0000;
  localparam logic [15:0] OFF_STAT = 16'h0004;
  localparam logic [15:0] OFF_CTRL = 16'h0008;

  localparam int STAT_TX_EMPTY = 0;
  localparam int STAT_TX_FULL  = 1;
  localparam int STAT_RX_EMPTY = 2;
  localparam int STAT_RX_FULL  = 3;
  localparam int STAT_BUSY     = 4;
  localparam int STAT_TX_OVF   = 8;
  localparam int STAT_RX_OVF   = 9;
  localparam int STAT_RX_UDF   = 10;
  localparam int STAT_CNT_LSB  = 16;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_TX_FLUSH = 1;
  localparam int CTRL_RX_FLUSH = 2;
  localparam int CTRL_IRQ_LSB  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_BUSY = 2'd2
  } spi_state_e;

  typedef enum logic [1:0] {
    REG_DATA = 2'd0,
    REG_STAT = 2'd1,
    REG_CTRL = 2'd2,
    REG_NONE = 2'd3
  } reg_sel_e;

  function automatic reg_sel_e decode_off(input logic [15:0] off);
    case (off)
      OFF_DATA: return REG_DATA;
      OFF_STAT: return REG_STAT;
      OFF_CTRL: return REG_CTRL;
      default:  return REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/spi_ahb_fifo_bridge_if.sv
// AHB-lite slave-side signal bundle for the bridge register window.
// master drives the address/data phases, slave returns registered read data.
interface spi_ahb_fifo_bridge_if;
  logic        hsel;
  logic        hwrite;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic [31:0] hrdata;

  modport master (output hsel, hwrite, haddr, hwdata, input hrdata);
  modport slave  (input hsel, hwrite, haddr, hwdata, output hrdata);
endinterface

// File: rtl/spi_ahb_fifo_bridge_fifo.sv
// Generic synchronous FIFO with flush; read data is the head entry (combinational, 0-cycle).
// A push while full is accepted only if a pop or flush frees room the same cycle; otherwise drop pulses.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             wdat,
  input  logic                     pop,
  output logic [W-1:0]             rdat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     drop
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, waddr;
  logic [CW-1:0] cnt;
  logic          do_push, do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign count   = cnt;
  assign rdat    = mem[rd_ptr];
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (!full || pop || flush);
  assign drop    = push && !do_push;
  // A flush coinciding with a push keeps the new word as the sole entry.
  assign waddr   = flush ? '0 : wr_ptr;

  always_ff @(posedge clk) begin
    if (do_push) mem[waddr] <= wdat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= do_push ? AW'(1) : '0;
      cnt    <= do_push ? CW'(1) : '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/spi_ahb_fifo_bridge.sv
// AHB register window feeding an SPI master core through TX/RX FIFOs, with sticky errors and irq.
// Reads return in the data phase; writes commit one cycle after the address phase; SPI word start costs 1 clk.
module spi_ahb_fifo_bridge
  import spi_bridge_pkg::*;
#(
  parameter int          DATA_W    = 8,
  parameter int          TX_DEPTH  = 8,
  parameter int          RX_DEPTH  = 8,
  parameter logic [15:0] ADDR_BASE = 16'h0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  spi_ahb_fifo_bridge_if.slave  bus,
  input  logic [DATA_W-1:0]     spi_data_out,
  input  logic                  spi_busy,
  output logic [DATA_W-1:0]     spi_data_in,
  output logic                  spi_ready_send,
  output logic                  irq
);
  localparam int TCW = $clog2(TX_DEPTH) + 1;
  localparam int RCW = $clog2(RX_DEPTH) + 1;

  // Address phase
  logic [15:0] a_off;
  reg_sel_e    a_sel;
  logic        rd_now, rx_pop_req;

  // Data phase
  logic     wr_pend;
  reg_sel_e wr_sel;
  logic     wr_data, wr_stat, wr_ctrl;

  logic       enable;
  logic [2:0] irq_en;
  logic       tx_ovf, rx_ovf, rx_udf;
  logic       tx_flush, rx_flush;

  logic [DATA_W-1:0] tx_rdat, rx_rdat;
  logic              tx_full, tx_empty, tx_drop, tx_pop;
  logic              rx_full, rx_empty, rx_drop, rx_push;
  logic [TCW-1:0]    tx_count_unused;
  logic [RCW-1:0]    rx_count;

  logic [31:0] stat_word, ctrl_word, rd_val;
  logic        unused_bits;

  spi_state_e state, state_d;
  logic       ready_d, load;

  assign a_off      = bus.haddr[15:0] - ADDR_BASE;
  assign a_sel      = decode_off(a_off);
  assign rd_now     = bus.hsel && !bus.hwrite;
  assign rx_pop_req = rd_now && (a_sel == REG_DATA);

  assign wr_data  = wr_pend && (wr_sel == REG_DATA);
  assign wr_stat  = wr_pend && (wr_sel == REG_STAT);
  assign wr_ctrl  = wr_pend && (wr_sel == REG_CTRL);
  assign tx_flush = wr_ctrl && bus.hwdata[CTRL_TX_FLUSH];
  assign rx_flush = wr_ctrl && bus.hwdata[CTRL_RX_FLUSH];

  assign unused_bits = ^{bus.haddr[31:16], bus.hwdata};

  sync_fifo #(.W(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (tx_flush),
    .push  (wr_data),
    .wdat  (bus.hwdata[DATA_W-1:0]),
    .pop   (tx_pop),
    .rdat  (tx_rdat),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count_unused),
    .drop  (tx_drop)
  );

  sync_fifo #(.W(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (rx_flush),
    .push  (rx_push),
    .wdat  (spi_data_out),
    .pop   (rx_pop_req),
    .rdat  (rx_rdat),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count),
    .drop  (rx_drop)
  );

  always_comb begin
    stat_word                       = '0;
    stat_word[STAT_TX_EMPTY]        = tx_empty;
    stat_word[STAT_TX_FULL]         = tx_full;
    stat_word[STAT_RX_EMPTY]        = rx_empty;
    stat_word[STAT_RX_FULL]         = rx_full;
    stat_word[STAT_BUSY]            = spi_busy || spi_ready_send || !tx_empty;
    stat_word[STAT_TX_OVF]          = tx_ovf;
    stat_word[STAT_RX_OVF]          = rx_ovf;
    stat_word[STAT_RX_UDF]          = rx_udf;
    stat_word[STAT_CNT_LSB +: 8]    = 8'(rx_count);
  end

  always_comb begin
    ctrl_word                       = '0;
    ctrl_word[CTRL_EN]              = enable;
    ctrl_word[CTRL_IRQ_LSB +: 3]    = irq_en;
  end

  // An empty-FIFO DATA read returns zero rather than a stale head entry.
  always_comb begin
    rd_val = '0;
    case (a_sel)
      REG_DATA: if (!rx_empty) rd_val[DATA_W-1:0] = rx_rdat;
      REG_STAT: rd_val = stat_word;
      REG_CTRL: rd_val = ctrl_word;
      default:  rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_pend    <= 1'b0;
      wr_sel     <= REG_NONE;
      bus.hrdata <= '0;
      enable     <= 1'b0;
      irq_en     <= '0;
      tx_ovf     <= 1'b0;
      rx_ovf     <= 1'b0;
      rx_udf     <= 1'b0;
    end else begin
      wr_pend <= bus.hsel && bus.hwrite;
      wr_sel  <= a_sel;
      if (rd_now) bus.hrdata <= rd_val;
      if (wr_ctrl) begin
        enable <= bus.hwdata[CTRL_EN];
        irq_en <= bus.hwdata[CTRL_IRQ_LSB +: 3];
      end
      // New errors win over a same-cycle write-1-to-clear.
      tx_ovf <= tx_drop | (tx_ovf & ~(wr_stat & bus.hwdata[STAT_TX_OVF]));
      rx_ovf <= rx_drop | (rx_ovf & ~(wr_stat & bus.hwdata[STAT_RX_OVF]));
      rx_udf <= (rx_pop_req & rx_empty) |
                (rx_udf & ~(wr_stat & bus.hwdata[STAT_RX_UDF]));
    end
  end

  assign irq = (irq_en[0] & tx_empty) |
               (irq_en[1] & !rx_empty) |
               (irq_en[2] & (tx_ovf | rx_ovf | rx_udf));

  always_comb begin
    state_d = state;
    ready_d = spi_ready_send;
    tx_pop  = 1'b0;
    rx_push = 1'b0;
    load    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable && !tx_empty && !spi_busy) begin
          tx_pop  = 1'b1;
          load    = 1'b1;
          ready_d = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (spi_busy) begin
          ready_d = 1'b0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (!spi_busy) begin
          rx_push = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        ready_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      spi_ready_send <= 1'b0;
      spi_data_in    <= '0;
    end else begin
      state          <= state_d;
      spi_ready_send <= ready_d;
      if (load) spi_data_in <= tx_rdat;
    end
  end

endmodule

// File: tb/tb_spi_ahb_fifo_bridge.sv
// Directed bench: stimulus queues expected read data and SPI words; monitors pop and compare.
// A behavioural SPI core answers each word with word ^ 8'h99 after a few clocks.
module tb_spi_ahb_fifo_bridge;

  localparam logic [31:0] A_DATA = 32'h1000_0040;
  localparam logic [31:0] A_STAT = 32'h1000_0044;
  localparam logic [31:0] A_CTRL = 32'h1000_0048;
  localparam logic [31:0] A_GAP  = 32'h1000_004C;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] spi_data_out = 8'h00;
  logic       spi_busy = 1'b0;
  logic [7:0] spi_data_in;
  logic       spi_ready_send;
  logic       irq;

  always #5 clk = ~clk;

  spi_ahb_fifo_bridge_if bus();

  spi_ahb_fifo_bridge #(
    .DATA_W    (8),
    .TX_DEPTH  (8),
    .RX_DEPTH  (8),
    .ADDR_BASE (16'h0040)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .spi_data_out   (spi_data_out),
    .spi_busy       (spi_busy),
    .spi_data_in    (spi_data_in),
    .spi_ready_send (spi_ready_send),
    .irq            (irq)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] rd_q[$];
  logic [7:0]  tx_q[$];
  logic        dphase_rd = 1'b0;
  logic        rs_prev = 1'b0;
  logic [31:0] pend_wd = '0;
  logic [7:0]  model_w;
  int          k;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One bus cycle: new address phase plus the data phase of the previous op.
  task automatic op(input logic sel, input logic wr, input logic [31:0] addr,
                    input logic [31:0] wd, input logic [31:0] exp);
    @(negedge clk);
    bus.hwdata = pend_wd;
    bus.hsel   = sel;
    bus.hwrite = wr;
    bus.haddr  = addr;
    if (sel && !wr) rd_q.push_back(exp);
    pend_wd = wd;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] wd);
    op(1'b1, 1'b1, addr, wd, 32'h0);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp);
    op(1'b1, 1'b0, addr, 32'h0, exp);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) op(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
  endtask

  always @(posedge clk) dphase_rd <= bus.hsel && !bus.hwrite;

  // Monitor: read data in the data phase, SPI word on each ready_send rise.
  always @(negedge clk) begin
    if (dphase_rd) begin
      if (rd_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL hrdata: got 0x%0h with no read expected", bus.hrdata);
      end else begin
        check("hrdata", bus.hrdata, rd_q.pop_front());
      end
    end
    if (spi_ready_send && !rs_prev) begin
      if (tx_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL spi_data_in: got 0x%0h with no word expected", spi_data_in);
      end else begin
        check("spi_data_in", {24'h0, spi_data_in}, {24'h0, tx_q.pop_front()});
      end
    end
    rs_prev = spi_ready_send;
  end

  // Behavioural SPI core.
  always begin
    @(negedge clk);
    if (spi_ready_send && !spi_busy) begin
      model_w = spi_data_in;
      @(negedge clk);
      spi_busy = 1'b1;
      repeat (3) @(negedge clk);
      spi_data_out = model_w ^ 8'h99;
      spi_busy     = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.hsel = 1'b0; bus.hwrite = 1'b0; bus.haddr = '0; bus.hwdata = '0;
    repeat (3) @(negedge clk);
    check("rst_ready_send", spi_ready_send, 0);
    check("rst_spi_data_in", spi_data_in, 0);
    check("rst_hrdata", bus.hrdata, 0);
    check("rst_irq", irq, 0);
    rst_n = 1'b1;
    rd(A_STAT, 32'h0000_0005);
    rd(A_CTRL, 32'h0);
    rd(A_GAP, 32'h0);
    idle(1);

    // Single word round trip
    tx_q.push_back(8'hA5);
    wr(A_CTRL, 32'h1);
    wr(A_DATA, 32'hA5);
    idle(1);
    @(negedge clk);
    check("t1_req_early", spi_ready_send, 0);
    @(negedge clk);
    check("t1_req", spi_ready_send, 1);
    idle(10);
    rd(A_STAT, 32'h0001_0001);
    rd(A_DATA, 32'h3C);
    rd(A_STAT, 32'h0000_0005);
    idle(1);

    // TX overflow with transfers disabled
    wr(A_CTRL, 32'h0);
    for (int i = 1; i <= 9; i++) wr(A_DATA, i);
    idle(2);
    rd(A_STAT, 32'h0000_0116);
    wr(A_STAT, 32'h100);
    idle(1);
    rd(A_STAT, 32'h0000_0016);
    idle(1);

    // Drain 8 words into RX, then overflow RX
    for (int i = 1; i <= 8; i++) tx_q.push_back(8'(i));
    wr(A_CTRL, 32'h1);
    idle(60);
    tx_q.push_back(8'hEE);
    wr(A_DATA, 32'hEE);
    idle(12);
    rd(A_STAT, 32'h0008_0209);
    for (int i = 1; i <= 8; i++) rd(A_DATA, 32'(8'(i) ^ 8'h99));
    rd(A_STAT, 32'h0000_0205);
    wr(A_STAT, 32'h200);
    idle(1);
    rd(A_STAT, 32'h0000_0005);

    // RX underflow and error interrupt
    rd(A_DATA, 32'h0);
    idle(1);
    rd(A_STAT, 32'h0000_0405);
    check("t3_irq_masked", irq, 0);
    wr(A_CTRL, 32'h401);
    idle(2);
    check("t3_irq_on", irq, 1);
    wr(A_STAT, 32'h400);
    idle(2);
    check("t3_irq_clr", irq, 0);
    rd(A_CTRL, 32'h0000_0401);
    idle(1);

    // Full TX: push collides with the first FSM pop
    for (int i = 0; i <= 8; i++) tx_q.push_back(8'hC0 + 8'(i));
    wr(A_CTRL, 32'h0);
    for (int i = 0; i < 8; i++) wr(A_DATA, 32'hC0 + i);
    wr(A_CTRL, 32'h1);
    wr(A_DATA, 32'hC8);
    rd(A_STAT, 32'h0000_0016);
    rd(A_STAT, 32'h0000_0016);
    idle(40);
    for (int i = 0; i < 4; i++) rd(A_DATA, 32'((8'hC0 + 8'(i)) ^ 8'h99));
    idle(40);
    for (int i = 4; i <= 8; i++) rd(A_DATA, 32'((8'hC0 + 8'(i)) ^ 8'h99));
    idle(1);
    rd(A_STAT, 32'h0000_0005);

    // Reset while the SPI core is mid-transfer
    tx_q.push_back(8'h11);
    wr(A_CTRL, 32'h101);
    wr(A_DATA, 32'h11);
    idle(1);
    for (k = 0; k < 20 && !(spi_busy && !spi_ready_send); k++) @(negedge clk);
    check("t5_busy_seen", (k < 20), 1);
    check("t5_irq_pre", irq, 1);
    rst_n = 1'b0;
    #1;
    check("t5_ready_send", spi_ready_send, 0);
    check("t5_spi_data_in", spi_data_in, 0);
    check("t5_hrdata", bus.hrdata, 0);
    check("t5_irq", irq, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(8);
    rd(A_STAT, 32'h0000_0005);
    rd(A_CTRL, 32'h0);
    idle(3);

    check("rd_queue_drained", rd_q.size(), 0);
    check("tx_queue_drained", tx_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
